// File: rtl/foo_stream_pkg.sv
// rtl/foo_stream_pkg.sv - shared types and width helpers for the foo_stream arithmetic pipe
package foo_stream_pkg;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_FLOOR = 1'b1
    } rnd_e;

    // Packed so that the 2-bit {sat_en, rnd} input maps directly onto it.
    typedef struct packed {
        logic sat_en;
        rnd_e rnd;
    } foo_mode_t;

    // Width of 3c+1 and 4d: both need two extra bits over the operand width.
    function automatic int p_w(input int width);
        return width + 2;
    endfunction

    // Width of (a-b)*(3c+1) - 4d, wide enough for every operand combination.
    function automatic int diff_w(input int width);
        return 2 * width + 4;
    endfunction

endpackage

// File: rtl/foo_stream_if.sv
// rtl/foo_stream_if.sv - operand/result stream bundle for foo_stream
//  Input side : in_vld, in_rdy, a_in..d_in, in_tag, in_mode
//  Output side: out_vld, out_rdy, res, res_tag, res_ovf
//  master = operand source / result consumer, slave = the arithmetic pipe
interface foo_stream_if
    import foo_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                    in_vld;
    logic                    in_rdy;
    logic signed [WIDTH-1:0] a_in;
    logic signed [WIDTH-1:0] b_in;
    logic signed [WIDTH-1:0] c_in;
    logic signed [WIDTH-1:0] d_in;
    logic [TAG_W-1:0]        in_tag;
    foo_mode_t               in_mode;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [WIDTH-1:0] res;
    logic [TAG_W-1:0]        res_tag;
    logic                    res_ovf;

    modport master (
        output in_vld, a_in, b_in, c_in, d_in, in_tag, in_mode, out_rdy,
        input  in_rdy, out_vld, res, res_tag, res_ovf
    );

    modport slave (
        input  in_vld, a_in, b_in, c_in, d_in, in_tag, in_mode, out_rdy,
        output in_rdy, out_vld, res, res_tag, res_ovf
    );
endinterface

// File: rtl/foo_stream_round_sat.sv
// rtl/foo_stream_round_sat.sv - halve a wide difference with trunc/floor rounding, flag and optionally clamp overflow
//  i_diff  in  DW     signed difference
//  i_mode  in  2      {sat_en, rnd}
//  o_res   out WIDTH  rounded, clamped or wrapped result
//  o_ovf   out 1      rounded quotient not representable in WIDTH bits
module foo_stream_round_sat
    import foo_stream_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int DW    = diff_w(WIDTH)
) (
    input  logic signed [DW-1:0]    i_diff,
    input  foo_mode_t               i_mode,
    output logic signed [WIDTH-1:0] o_res,
    output logic                    o_ovf
);
    localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [DW-1:0] w_adj;
    logic signed [DW-1:0] w_q;
    logic                 w_trunc_fix;

    // An arithmetic shift floors; bumping odd negatives by one first turns it into truncation.
    // Even negatives are unaffected because the added bit falls off in the shift.
    assign w_trunc_fix = (i_mode.rnd == RND_TRUNC) && i_diff[DW-1];
    assign w_adj       = i_diff + {{(DW-1){1'b0}}, w_trunc_fix};
    assign w_q         = w_adj >>> 1;

    // Representable iff every bit from the result sign bit upward is identical.
    assign o_ovf = !((&w_q[DW-1:WIDTH-1]) || !(|w_q[DW-1:WIDTH-1]));

    always_comb begin
        o_res = w_q[WIDTH-1:0];
        if (i_mode.sat_en && o_ovf) begin
            o_res = w_q[DW-1] ? RES_MIN : RES_MAX;
        end
    end
endmodule

// File: rtl/foo_stream.sv
// rtl/foo_stream.sv - 4-stage elastic pipe computing ((a-b)*(3c+1) - 4d) / 2 with tag, mode and overflow
//  clk  in  1   clock
//  rst  in  1   synchronous active-high reset
//  bus  slave   operand stream in, result stream out (see foo_stream_if)
module foo_stream
    import foo_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    foo_stream_if.slave  bus
);
    localparam int PW = p_w(WIDTH);
    localparam int MW = 2 * WIDTH + 3;
    localparam int DW = diff_w(WIDTH);

    logic [3:0] r_v;
    logic [4:0] w_rdy;

    // S0: registered operands
    logic [WIDTH-1:0] r0_a, r0_b, r0_c, r0_d;
    logic [TAG_W-1:0] r0_tag;
    foo_mode_t        r0_mode;
    // S1: partial terms
    logic [WIDTH:0]   r1_p1;
    logic [PW-1:0]    r1_p2, r1_p3;
    logic [TAG_W-1:0] r1_tag;
    foo_mode_t        r1_mode;
    // S2: product
    logic [MW-1:0]    r2_m;
    logic [PW-1:0]    r2_p3;
    logic [TAG_W-1:0] r2_tag;
    foo_mode_t        r2_mode;
    // S3: result
    logic [WIDTH-1:0] r3_res;
    logic [TAG_W-1:0] r3_tag;
    logic             r3_ovf;

    logic [WIDTH:0]          w_p1;
    logic [PW-1:0]           w_c_ext, w_p2, w_p3;
    logic signed [MW-1:0]    w_m;
    logic signed [DW-1:0]    w_diff;
    logic signed [WIDTH-1:0] w_res;
    logic                    w_ovf;

    // A stage may load when it is empty or its content moves on this same edge.
    assign w_rdy[4] = bus.out_rdy;
    assign w_rdy[3] = !r_v[3] || w_rdy[4];
    assign w_rdy[2] = !r_v[2] || w_rdy[3];
    assign w_rdy[1] = !r_v[1] || w_rdy[2];
    assign w_rdy[0] = !r_v[0] || w_rdy[1];

    assign w_p1    = {r0_a[WIDTH-1], r0_a} - {r0_b[WIDTH-1], r0_b};
    assign w_c_ext = {{2{r0_c[WIDTH-1]}}, r0_c};
    assign w_p2    = (w_c_ext <<< 1) + w_c_ext + PW'(1);
    assign w_p3    = {r0_d, 2'b00};

    assign w_m = $signed({{(MW-WIDTH-1){r1_p1[WIDTH]}}, r1_p1})
               * $signed({{(MW-PW){r1_p2[PW-1]}}, r1_p2});

    assign w_diff = {r2_m[MW-1], r2_m} - {{(DW-PW){r2_p3[PW-1]}}, r2_p3};

    foo_stream_round_sat #(.WIDTH(WIDTH)) u_round_sat (
        .i_diff (w_diff),
        .i_mode (r2_mode),
        .o_res  (w_res),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r0_a    <= '0; r0_b <= '0; r0_c <= '0; r0_d <= '0;
            r0_tag  <= '0; r0_mode <= '0;
            r1_p1   <= '0; r1_p2 <= '0; r1_p3 <= '0;
            r1_tag  <= '0; r1_mode <= '0;
            r2_m    <= '0; r2_p3 <= '0;
            r2_tag  <= '0; r2_mode <= '0;
            r3_res  <= '0; r3_tag <= '0; r3_ovf <= 1'b0;
        end else begin
            if (w_rdy[0]) r_v[0] <= bus.in_vld;
            if (w_rdy[1]) r_v[1] <= r_v[0];
            if (w_rdy[2]) r_v[2] <= r_v[1];
            if (w_rdy[3]) r_v[3] <= r_v[2];

            // Data registers load only on a real transfer so idle inputs never enter the pipe.
            if (bus.in_vld && w_rdy[0]) begin
                r0_a    <= bus.a_in;
                r0_b    <= bus.b_in;
                r0_c    <= bus.c_in;
                r0_d    <= bus.d_in;
                r0_tag  <= bus.in_tag;
                r0_mode <= bus.in_mode;
            end
            if (r_v[0] && w_rdy[1]) begin
                r1_p1   <= w_p1;
                r1_p2   <= w_p2;
                r1_p3   <= w_p3;
                r1_tag  <= r0_tag;
                r1_mode <= r0_mode;
            end
            if (r_v[1] && w_rdy[2]) begin
                r2_m    <= w_m;
                r2_p3   <= r1_p3;
                r2_tag  <= r1_tag;
                r2_mode <= r1_mode;
            end
            if (r_v[2] && w_rdy[3]) begin
                r3_res <= w_res;
                r3_tag <= r2_tag;
                r3_ovf <= w_ovf;
            end
        end
    end

    assign bus.in_rdy  = w_rdy[0];
    assign bus.out_vld = r_v[3];
    assign bus.res     = r3_res;
    assign bus.res_tag = r3_tag;
    assign bus.res_ovf = r3_ovf;
endmodule
